// File: rtl/seven_segment_anim_sequencer.sv
// Animation sequencer for the 7-segment FUN display: debounced buttons select the
// animation, frame period and pause state, and drive a free-running frame counter.
module seven_segment_anim_sequencer #(
    // 25 bits are needed to hold PERIOD_MAX = 19_000_000
    parameter int CNT_W       = 25,
    parameter int PERIOD_DEF  = 10_000_000,
    parameter int PERIOD_MIN  = 1_000_000,
    parameter int PERIOD_MAX  = 19_000_000,
    parameter int PERIOD_STEP = 1_000_000,
    parameter int DEB_CYCLES  = 512,
    parameter int NUM_ANIM    = 12,
    parameter int ANIM_W      = 4,
    parameter int FRAME_W     = 5,
    parameter bit WRAP        = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_next,
    input  logic               btn_prev,
    input  logic               btn_faster,
    input  logic               btn_slower,
    input  logic               btn_pause,
    input  logic [FRAME_W-1:0] frame_limit,
    output logic [ANIM_W-1:0]  anim_idx,
    output logic [FRAME_W-1:0] frame,
    output logic               frame_tick,
    output logic [CNT_W-1:0]   period,
    output logic               paused
);

    localparam int NB    = 5;
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
    localparam int B_NEXT   = 0;
    localparam int B_PREV   = 1;
    localparam int B_FASTER = 2;
    localparam int B_SLOWER = 3;
    localparam int B_PAUSE  = 4;

    localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEB_CYCLES);
    localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [ANIM_W-1:0] IDX_LAST = ANIM_W'(NUM_ANIM - 1);
    localparam logic [CNT_W:0]    MIN_E    = (CNT_W+1)'(PERIOD_MIN);
    localparam logic [CNT_W:0]    MAX_E    = (CNT_W+1)'(PERIOD_MAX);
    localparam logic [CNT_W:0]    STEP_E   = (CNT_W+1)'(PERIOD_STEP);

    logic [NB-1:0]      raw;
    logic [NB-1:0]      sync1;
    logic [NB-1:0]      sync2;
    logic [NB-1:0]      evt;
    logic [DEB_W-1:0]   deb_cnt [NB];
    logic [CNT_W-1:0]   cyc_cnt;
    logic [ANIM_W-1:0]  next_idx;
    logic [CNT_W-1:0]   next_period;
    logic [CNT_W:0]     per_ext;
    logic [CNT_W:0]     per_sum;
    logic               idx_change;

    assign raw = {btn_pause, btn_slower, btn_faster, btn_prev, btn_next};

    // NOTE: the debounce counters are a handful of flops, not a RAM, so they are
    // cleared by reset like any other state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            for (int i = 0; i < NB; i++) deb_cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < NB; i++) begin
                if (!sync2[i])
                    deb_cnt[i] <= '0;
                else if (deb_cnt[i] != DEB_MAX)
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
        end
    end

    // One event per press: only the step from DEB_CYCLES-1 to DEB_CYCLES fires.
    // NOTE: combinational blocks assign every output a default first so no latch
    // can be inferred, and use blocking assignments throughout.
    always_comb begin
        evt = '0;
        for (int i = 0; i < NB; i++)
            evt[i] = sync2[i] && (deb_cnt[i] == DEB_LAST);
    end

    always_comb begin
        next_idx = anim_idx;
        if (evt[B_NEXT] && !evt[B_PREV]) begin
            if (anim_idx == IDX_LAST) next_idx = WRAP ? '0 : anim_idx;
            else                      next_idx = anim_idx + 1'b1;
        end else if (evt[B_PREV] && !evt[B_NEXT]) begin
            if (anim_idx == '0) next_idx = WRAP ? IDX_LAST : anim_idx;
            else                next_idx = anim_idx - 1'b1;
        end
        idx_change = (next_idx != anim_idx);
    end

    // Saturating speed change, done one bit wider so neither end can wrap.
    always_comb begin
        per_ext     = {1'b0, period};
        per_sum     = per_ext + STEP_E;
        next_period = period;
        if (evt[B_FASTER] && !evt[B_SLOWER]) begin
            if (per_ext < MIN_E + STEP_E) next_period = MIN_E[CNT_W-1:0];
            else                          next_period = CNT_W'(per_ext - STEP_E);
        end else if (evt[B_SLOWER] && !evt[B_FASTER]) begin
            if (per_sum > MAX_E) next_period = MAX_E[CNT_W-1:0];
            else                 next_period = per_sum[CNT_W-1:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            anim_idx   <= '0;
            frame      <= '0;
            frame_tick <= 1'b0;
            period     <= CNT_W'(PERIOD_DEF);
            paused     <= 1'b0;
            cyc_cnt    <= '0;
        end else begin
            frame_tick <= 1'b0;
            anim_idx   <= next_idx;
            period     <= next_period;
            if (evt[B_PAUSE]) paused <= !paused;

            if (idx_change) begin
                cyc_cnt <= '0;
                frame   <= '0;
            end else if (!paused) begin
                // >= lets a shortened period take effect without a counter overrun
                if (cyc_cnt >= period - 1'b1) begin
                    cyc_cnt    <= '0;
                    frame_tick <= 1'b1;
                    frame      <= (frame >= frame_limit) ? '0 : frame + 1'b1;
                end else begin
                    cyc_cnt <= cyc_cnt + 1'b1;
                end
            end
        end
    end

endmodule
